// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator and the execute-stage target calculator:
// sequencer states, legal step sizes and the alignment mask helper.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int STEP_WORD = 4;
  localparam int STEP_HALF = 2;

  // Low address bits that must be zero for a PC aligned to the given step.
  function automatic logic [1:0] mask(input int step);
    return (step == STEP_HALF) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake plus redirect request/report signals of the PC generator.
// The master side is pc_gen; the slave side is the fetch/branch/trap logic.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    logic            br_taken;
    logic [XLEN-1:0] br_base;
    logic [XLEN-1:0] br_offset;
    logic            br_jalr;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;

    modport master (
        output fetch_valid, fetch_pc, misalign_err, misalign_addr,
        input  fetch_ready, br_taken, br_base, br_offset, br_jalr, trap_req, trap_vec
    );

    modport slave (
        input  fetch_valid, fetch_pc, misalign_err, misalign_addr,
        output fetch_ready, br_taken, br_base, br_offset, br_jalr, trap_req, trap_vec
    );
endinterface

// File: rtl/pc_tgt_calc.sv
// Control-transfer target adder with JALR bit-0 clearing and alignment check.
// Purely combinational so the execute-stage branch unit can share it.
module pc_tgt_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic            jalr,
    output logic [XLEN-1:0] tgt,
    output logic            misaligned
);
    logic [XLEN-1:0] sum;

    assign sum        = base + offset;
    assign tgt        = {sum[XLEN-1:1], sum[0] & ~jalr};
    assign misaligned = |(tgt[1:0] & mask(STEP));
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: steps the PC, offers it over valid/ready, and applies
// trap/branch redirects with trap > branch > increment priority.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4
) (
    input logic    CLK,
    input logic    reset,
    pc_gen_if.master bus
);
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, mask(STEP)};

    pc_state_e       state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] addr, addr_n;
    logic            valid;
    logic            err, err_n;
    logic [XLEN-1:0] tgt;
    logic            tgt_bad;

    pc_tgt_calc #(
        .XLEN(XLEN),
        .STEP(STEP)
    ) u_tgt (
        .base      (bus.br_base),
        .offset    (bus.br_offset),
        .jalr      (bus.br_jalr),
        .tgt       (tgt),
        .misaligned(tgt_bad)
    );

    // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr;
        err_n   = 1'b0;
        if (bus.trap_req) begin
            pc_n    = bus.trap_vec & ALIGN_MASK;
            state_n = ST_RUN;
        end else begin
            unique case (state)
                ST_WAIT, ST_RUN: begin
                    if (bus.br_taken) begin
                        if (tgt_bad) begin
                            err_n   = 1'b1;
                            addr_n  = tgt;
                            state_n = ST_HALT;
                        end else begin
                            pc_n    = tgt;
                            state_n = ST_RUN;
                        end
                    end else if (state == ST_WAIT) begin
                        state_n = ST_RUN;
                    end else if (valid && bus.fetch_ready) begin
                        pc_n = pc + STEP_INC;
                    end
                end
                default: state_n = ST_HALT;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= ST_WAIT;
            pc    <= RESET_VEC;
            valid <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            valid <= (state_n == ST_RUN);
            err   <= err_n;
            addr  <= addr_n;
        end
    end

    assign bus.fetch_valid   = valid;
    assign bus.fetch_pc      = pc;
    assign bus.misalign_err  = err;
    assign bus.misalign_addr = addr;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a STEP=4 and a STEP=2 instance share stimulus; directed table,
// hand-written corner sequences, then random traffic against an abstract model.
module tb_pc_gen;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h100;

    typedef struct packed {
        logic        rst;
        logic        ready;
        logic        br;
        logic [31:0] base;
        logic [31:0] off;
        logic        jalr;
        logic        trap;
        logic [31:0] tvec;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic        err;
        logic [31:0] addr;
    } model_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] pc;
        logic        valid;
        logic        err;
        logic [31:0] addr;
    } vec_t;

    logic CLK = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    model_t m4, m2;
    vec_t   vecs[$];

    always #5 CLK = ~CLK;

    pc_gen_if #(.XLEN(XLEN)) bus4 ();
    pc_gen_if #(.XLEN(XLEN)) bus2 ();

    pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .STEP(4)) dut4 (.CLK(CLK), .reset(reset), .bus(bus4.master));
    pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .STEP(2)) dut2 (.CLK(CLK), .reset(reset), .bus(bus2.master));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic ready, input logic br,
                                 input logic [31:0] base, input logic [31:0] off,
                                 input logic jalr, input logic trap, input logic [31:0] tvec);
        stim_t s;
        s.rst = rst; s.ready = ready; s.br = br; s.base = base;
        s.off = off; s.jalr = jalr; s.trap = trap; s.tvec = tvec;
        return s;
    endfunction

    function automatic stim_t idle(input logic ready);
        return mk(1'b0, ready, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endfunction

    // Behaviour from the rules: reset, trap, halt latch, branch or flag, bubble, increment.
    function automatic model_t model_step(input model_t m, input int step, input stim_t s);
        model_t      n;
        logic [31:0] stepv;
        logic [31:0] tgt;
        n     = m;
        stepv = 32'(step);
        tgt   = s.base + s.off;
        if (s.jalr) tgt = tgt & 32'hFFFF_FFFE;
        n.err = 1'b0;
        if (s.rst) begin
            n.pc = RV; n.valid = 1'b0; n.halted = 1'b0; n.addr = 32'h0;
        end else if (s.trap) begin
            n.pc = s.tvec - (s.tvec % stepv); n.valid = 1'b1; n.halted = 1'b0;
        end else if (m.halted) begin
            n.valid = 1'b0;
        end else if (s.br) begin
            if ((tgt % stepv) != 0) begin
                n.err = 1'b1; n.addr = tgt; n.halted = 1'b1; n.valid = 1'b0;
            end else begin
                n.pc = tgt; n.valid = 1'b1;
            end
        end else if (!m.valid) begin
            n.valid = 1'b1;
        end else if (s.ready) begin
            n.pc = m.pc + stepv;
        end
        return n;
    endfunction

    task automatic drive(input stim_t s);
        reset            = s.rst;
        bus4.fetch_ready = s.ready; bus2.fetch_ready = s.ready;
        bus4.br_taken    = s.br;    bus2.br_taken    = s.br;
        bus4.br_base     = s.base;  bus2.br_base     = s.base;
        bus4.br_offset   = s.off;   bus2.br_offset   = s.off;
        bus4.br_jalr     = s.jalr;  bus2.br_jalr     = s.jalr;
        bus4.trap_req    = s.trap;  bus2.trap_req    = s.trap;
        bus4.trap_vec    = s.tvec;  bus2.trap_vec    = s.tvec;
    endtask

    // One clock: drive, advance the models, sample 1 time unit after the edge.
    task automatic step(input stim_t s);
        drive(s);
        @(posedge CLK);
        m4 = model_step(m4, 4, s);
        m2 = model_step(m2, 2, s);
        #1;
        check("s4_pc",    bus4.fetch_pc,              m4.pc);
        check("s4_valid", 32'(bus4.fetch_valid),      32'(m4.valid));
        check("s4_err",   32'(bus4.misalign_err),     32'(m4.err));
        check("s4_addr",  bus4.misalign_addr,         m4.addr);
        check("s2_pc",    bus2.fetch_pc,              m2.pc);
        check("s2_valid", 32'(bus2.fetch_valid),      32'(m2.valid));
        check("s2_err",   32'(bus2.misalign_err),     32'(m2.err));
        check("s2_addr",  bus2.misalign_addr,         m2.addr);
    endtask

    task automatic add(input stim_t s, input logic [31:0] pc, input logic v,
                       input logic e, input logic [31:0] a);
        vec_t t;
        t.s = s; t.pc = pc; t.valid = v; t.err = e; t.addr = a;
        vecs.push_back(t);
    endtask

    initial begin
        m4 = '0;
        m2 = '0;

        // Directed vectors with expected values for the STEP=4 instance.
        add(mk(1, 1, 0, 0, 0, 0, 0, 0),                         32'h100, 0, 0, 32'h0);
        add(idle(1),                                            32'h100, 1, 0, 32'h0);
        add(idle(1),                                            32'h104, 1, 0, 32'h0);
        add(idle(1),                                            32'h108, 1, 0, 32'h0);
        add(mk(0, 1, 1, 32'h200, 0, 0, 0, 0),                   32'h200, 1, 0, 32'h0);
        add(idle(0),                                            32'h200, 1, 0, 32'h0);
        add(idle(0),                                            32'h200, 1, 0, 32'h0);
        add(idle(0),                                            32'h200, 1, 0, 32'h0);
        add(idle(1),                                            32'h204, 1, 0, 32'h0);
        add(mk(0, 1, 1, 32'h1000, 32'hFFFF_FFF8, 0, 0, 0),      32'hFF8, 1, 0, 32'h0);
        add(idle(1),                                            32'hFFC, 1, 0, 32'h0);
        add(mk(0, 1, 1, 32'h500, 0, 0, 1, 32'h83),              32'h80,  1, 0, 32'h0);
        add(mk(0, 1, 1, 32'h502, 0, 0, 1, 32'h40),              32'h40,  1, 0, 32'h0);
        add(mk(0, 0, 1, 32'h301, 0, 1, 0, 0),                   32'h300, 1, 0, 32'h0);
        add(mk(0, 1, 1, 32'h302, 0, 1, 0, 0),                   32'h300, 0, 1, 32'h302);
        add(mk(0, 1, 1, 32'h400, 0, 0, 0, 0),                   32'h300, 0, 0, 32'h302);
        add(mk(0, 1, 0, 0, 0, 0, 1, 32'h80),                    32'h80,  1, 0, 32'h302);
        add(mk(0, 1, 1, 32'hFFFF_FFF0, 32'hC, 0, 0, 0),         32'hFFFF_FFFC, 1, 0, 32'h302);
        add(idle(1),                                            32'h0,   1, 0, 32'h302);
        add(mk(0, 1, 1, 32'h11, 0, 0, 0, 0),                    32'h0,   0, 1, 32'h11);
        add(mk(1, 1, 1, 32'h200, 0, 0, 1, 32'h80),              32'h100, 0, 0, 32'h0);
        add(idle(0),                                            32'h100, 1, 0, 32'h0);
        add(mk(1, 0, 0, 0, 0, 0, 0, 0),                         32'h100, 0, 0, 32'h0);
        add(mk(0, 0, 1, 32'h600, 0, 0, 0, 0),                   32'h600, 1, 0, 32'h0);

        foreach (vecs[i]) begin
            step(vecs[i].s);
            check($sformatf("v%0d_pc", i),    bus4.fetch_pc,          vecs[i].pc);
            check($sformatf("v%0d_valid", i), 32'(bus4.fetch_valid),  32'(vecs[i].valid));
            check($sformatf("v%0d_err", i),   32'(bus4.misalign_err), 32'(vecs[i].err));
            check($sformatf("v%0d_addr", i),  bus4.misalign_addr,     vecs[i].addr);
        end

        // Compressed-step corners: JALR target 0x301 lands aligned, trap vector keeps bit 1.
        step(mk(1, 1, 0, 0, 0, 0, 0, 0));
        step(mk(0, 1, 1, 32'h301, 0, 1, 0, 0));
        check("c2_jalr_pc",  bus2.fetch_pc,          32'h300);
        check("c2_jalr_err", 32'(bus2.misalign_err), 32'h0);
        step(idle(1));
        check("c2_inc_pc",   bus2.fetch_pc,          32'h302);
        step(mk(0, 1, 0, 0, 0, 0, 1, 32'h83));
        check("c2_trap_pc",  bus2.fetch_pc,          32'h82);
        check("c4_trap_pc",  bus4.fetch_pc,          32'h80);

        // Misaligned target in the post-reset bubble halts directly from WAIT.
        step(mk(1, 1, 0, 0, 0, 0, 0, 0));
        step(mk(0, 1, 1, 32'h7, 0, 0, 0, 0));
        check("c4_wait_err",   32'(bus4.misalign_err), 32'h1);
        check("c4_wait_valid", 32'(bus4.fetch_valid),  32'h0);
        step(idle(1));
        check("c4_halt_hold",  bus4.fetch_pc,          32'h100);
        check("c4_err_pulse",  32'(bus4.misalign_err), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            stim_t       s;
            logic [31:0] base;
            logic [31:0] off;
            base = $urandom;
            if ($urandom_range(1) == 0) base[1:0] = 2'b00;
            if ($urandom_range(7) == 0) base = 32'hFFFF_FFF0 | (base & 32'hC);
            off = ($urandom_range(3) == 0) ? $urandom : (32'($urandom_range(255)) - 32'd128);
            s = mk($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0,
                   base, off, 1'($urandom_range(1)), $urandom_range(15) == 0, $urandom);
            step(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
